ocra1_grad_seq: RTL

//  Upstream feeder for the OCRA1 serial interface core.

---
 rtl/ocra1_grad_seq_pkg.sv | 60 ++++++
 rtl/ocra1_frame_fifo.sv | 52 +++++
 rtl/ocra1_grad_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ocra1_grad_seq_pkg.sv
// Shared constants, state encoding and word helpers for the OCRA1
// gradient sequencer: channel indices, word fields, init payload.
package ocra1_grad_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_INIT = 2'd3
  } state_t;

  localparam logic [1:0] CH_X  = 2'd0;
  localparam logic [1:0] CH_Y  = 2'd1;
  localparam logic [1:0] CH_Z  = 2'd2;
  localparam logic [1:0] CH_Z2 = 2'd3;

  localparam int W_CH_LSB = 25;
  localparam int W_LDAC   = 24;
  localparam int W_PL_LSB = 0;

  localparam int CODE_W = 18;
  localparam int FRAME_W = 4 * CODE_W;

  localparam logic [23:0] INIT_PAYLOAD = 24'h200002;
  localparam logic [3:0]  VAL_PREFIX   = 4'h1;

  localparam logic [17:0] SAT_POS = 18'h1FFFF;
  localparam logic [17:0] SAT_NEG = 18'h20000;

  function automatic logic [31:0] mk_word(
    input logic [1:0]  ch,
    input logic [23:0] pl
  );
    logic [31:0] w;
    w = '0;
    w[W_CH_LSB +: 2]  = ch;
    w[W_LDAC]         = (ch == CH_Z2);
    w[W_PL_LSB +: 24] = pl;
    return w;
  endfunction

  function automatic logic [17:0] val_code(
    input logic [17:0] c
  );
    return c;
  endfunction

  // Sum at 19 bits; overflow when the two top bits differ.
  function automatic logic [17:0] sat18(
    input logic [17:0] a,
    input logic [17:0] b
  );
    logic [18:0] s;
    s = {a[17], a} + {b[17], b};
    if (s[18] != s[17])
      return s[18] ? SAT_NEG : SAT_POS;
    return s[17:0];
  endfunction

endpackage

// File: rtl/ocra1_frame_fifo.sv
// Synchronous frame FIFO with level output and pass-through at full.
// Ports: wr_data/wr_valid/wr_ready in, rd_data/rd_en/empty/level out.
module ocra1_frame_fifo #(
  parameter int AW = 4,
  parameter int W  = 72
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [W-1:0]  rd_data,
  input  logic          rd_en,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         full;
  logic         push;
  logic         pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW])
              && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot being written.
  assign wr_ready = !full || pop;
  assign push  = wr_valid && wr_ready;
  assign level = wp - rp;
  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push)
      mem[wp[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/ocra1_grad_seq.sv
// OCRA1 gradient sequencer: frame FIFO, update timer, word FSM, flags.
// Ports: frame in (72b), timer ctl, init req, core status, 32b word out,
// FIFO level, sticky underrun/overrun/data_lost.
// Optional OCRA1_GRAD_OFFSET_EN adds offset_i and a saturating add stage.
module ocra1_grad_seq
  import ocra1_grad_seq_pkg::*;
#(
  parameter int FIFO_AW    = 4,
  parameter int PERIOD_MIN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [71:0]       frame_i,
  input  logic              frame_valid_i,
  output logic              frame_ready_o,
  input  logic              enable_i,
  input  logic [15:0]       period_i,
  input  logic              init_i,
  input  logic              busy_i,
  input  logic              data_lost_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  output logic [FIFO_AW:0]  fifo_level_o,
  output logic              underrun_o,
  output logic              overrun_o,
  output logic              data_lost_o
`ifdef OCRA1_GRAD_OFFSET_EN
  ,
  input  logic [71:0]       offset_i
`endif
);

  state_t       state;
  state_t       state_n;
  logic [1:0]   idx;
  logic [1:0]   idx_n;
  logic [15:0]  cnt;
  logic [15:0]  reload;
  logic         tick;
  logic         tick_pend;
  logic         init_pend;
  logic [71:0]  frame_q;
  logic [71:0]  fifo_data;
  logic         fifo_empty;
  logic         pop;
  logic         enter_init;
  logic         clr_tick;
  logic         set_under;
  logic         out_v;
  logic [31:0]  out_w;
  logic [17:0]  code;
  logic [23:0]  pl;

`ifdef OCRA1_GRAD_OFFSET_EN
  logic [71:0]  raw_q;
  logic [71:0]  ofs_q;
`endif

  ocra1_frame_fifo #(
    .AW (FIFO_AW),
    .W  (FRAME_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (frame_i),
    .wr_valid (frame_valid_i),
    .wr_ready (frame_ready_o),
    .rd_data  (fifo_data),
    .rd_en    (pop),
    .empty    (fifo_empty),
    .level    (fifo_level_o)
  );

  assign reload = (period_i < 16'(PERIOD_MIN))
                ? 16'(PERIOD_MIN - 1)
                : period_i - 16'd1;
  assign tick = enable_i && (cnt == 16'd0);

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    pop        = 1'b0;
    enter_init = 1'b0;
    clr_tick   = 1'b0;
    set_under  = 1'b0;
    out_v      = 1'b0;
    out_w      = '0;
    code       = frame_q[18*int'(idx) +: 18];
    pl         = {VAL_PREFIX, val_code(code), 2'b00};
    unique case (state)
      ST_IDLE: begin
        if (init_pend && !busy_i) begin
          state_n    = ST_INIT;
          enter_init = 1'b1;
        end else if (tick_pend && !busy_i) begin
          clr_tick = 1'b1;
          if (!fifo_empty) begin
            pop = 1'b1;
`ifdef OCRA1_GRAD_OFFSET_EN
            state_n = ST_LOAD;
`else
            state_n = ST_SEND;
`endif
          end else begin
            set_under = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        state_n = ST_SEND;
      end
      ST_SEND, ST_INIT: begin
        out_v = 1'b1;
        if (state == ST_INIT)
          pl = INIT_PAYLOAD;
        out_w = mk_word(idx, pl);
        idx_n = idx + 2'd1;
        if (idx == CH_Z2)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      tick_pend   <= 1'b0;
      init_pend   <= 1'b0;
      state       <= ST_IDLE;
      idx         <= CH_X;
      data_o      <= '0;
      valid_o     <= 1'b0;
      underrun_o  <= 1'b0;
      overrun_o   <= 1'b0;
      data_lost_o <= 1'b0;
      frame_q     <= '0;
    end else begin
      if (!enable_i)
        cnt <= '0;
      else if (tick)
        cnt <= reload;
      else
        cnt <= cnt - 16'd1;

      // A tick arriving while one is pending merges into it.
      if (tick)
        tick_pend <= 1'b1;
      else if (clr_tick)
        tick_pend <= 1'b0;
      if (tick && tick_pend)
        overrun_o <= 1'b1;
      if (set_under)
        underrun_o <= 1'b1;
      if (data_lost_i)
        data_lost_o <= 1'b1;

      if (enter_init)
        init_pend <= 1'b0;
      else if (init_i)
        init_pend <= 1'b1;

      state   <= state_n;
      idx     <= idx_n;
      data_o  <= out_w;
      valid_o <= out_v;

`ifdef OCRA1_GRAD_OFFSET_EN
      if (state == ST_LOAD) begin
        for (int c = 0; c < 4; c++)
          frame_q[18*c +: 18] <= sat18(raw_q[18*c +: 18],
                                       ofs_q[18*c +: 18]);
      end
`else
      if (pop)
        frame_q <= fifo_data;
`endif
    end
  end

`ifdef OCRA1_GRAD_OFFSET_EN
  // Offset is captured together with the frame at pop time.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= '0;
      ofs_q <= '0;
    end else if (pop) begin
      raw_q <= fifo_data;
      ofs_q <= offset_i;
    end
  end
`endif

endmodule
